// File: rtl/spi_burst_master.sv
// SPI mode-3 burst master: one header byte {rw, ms, addr[5:0]} followed by up to MAX_BYTES data bytes.
// cs, spc, sdi are registered. tx_ready and done are decoded from registered state.
module spi_burst_master #(
    parameter int CLK_DIV   = 4,
    parameter int MAX_BYTES = 6,
    parameter int CS_GAP    = 2,
    localparam int LW       = $clog2(MAX_BYTES + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_rw,
    input  logic [5:0]    cmd_addr,
    input  logic [LW-1:0] cmd_len,
    input  logic [7:0]    tx_data,
    output logic          tx_ready,
    output logic [7:0]    rx_data,
    output logic          rx_valid,
    output logic          busy,
    output logic          done,
    input  logic          sdo,
    output logic          cs,
    output logic          spc,
    output logic          sdi
);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

    localparam logic [7:0]    DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0]    GAP_LAST = 8'(CS_GAP - 1);
    localparam logic [LW-1:0] MAX_LEN  = LW'(MAX_BYTES);
    localparam logic [LW-1:0] ONE_LEN  = LW'(1);

    state_t        r_state, w_state_next;
    logic [7:0]    r_div, w_div_next;
    logic [7:0]    r_gap, w_gap_next;
    logic [2:0]    r_bit, w_bit_next;
    logic [LW-1:0] r_byte, w_byte_next;
    logic [LW-1:0] r_len, w_len_next;
    logic          r_rw, w_rw_next;
    logic [7:0]    r_sh, w_sh_next;
    logic [7:0]    r_rxsh, w_rxsh_next;
    logic          r_rx_pend, w_rx_pend_next;
    logic          r_rx_valid, w_rx_valid_next;
    logic [7:0]    r_rx_data, w_rx_data_next;
    logic          r_cs, w_cs_next;
    logic          r_spc, w_spc_next;
    logic          r_sdi, w_sdi_next;
    logic          r_cmd_ready, w_cmd_ready_next;

    logic [LW-1:0] w_len;
    logic [7:0]    w_header;
    logic [7:0]    w_new_byte;
    logic          w_div_end;
    logic          w_last_bit;
    logic          w_last_byte;

    assign w_len       = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;
    assign w_header    = {cmd_rw, (w_len > ONE_LEN), cmd_addr};
    assign w_new_byte  = r_rw ? 8'h00 : tx_data;
    assign w_div_end   = (r_div == DIV_LAST);
    assign w_last_bit  = (r_bit == 3'd7);
    assign w_last_byte = (r_byte == r_len);

    // tx_ready marks the cycle whose closing edge is the falling edge that loads the next write byte.
    assign tx_ready  = (r_state == S_SHIFT) && r_spc && w_div_end && w_last_bit && !w_last_byte && !r_rw;
    assign done      = (r_state == S_GAP) && (r_gap == GAP_LAST);
    assign busy      = (r_state != S_IDLE);
    assign cmd_ready = r_cmd_ready;
    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign cs        = r_cs;
    assign spc       = r_spc;
    assign sdi       = r_sdi;

    always_comb begin
        // NOTE: every next-value gets a default before the case, so no path leaves one unassigned and no latch is inferred.
        w_state_next     = r_state;
        w_div_next       = r_div;
        w_gap_next       = r_gap;
        w_bit_next       = r_bit;
        w_byte_next      = r_byte;
        w_len_next       = r_len;
        w_rw_next        = r_rw;
        w_sh_next        = r_sh;
        w_rxsh_next      = r_rxsh;
        w_cs_next        = r_cs;
        w_spc_next       = r_spc;
        w_sdi_next       = r_sdi;
        w_cmd_ready_next = r_cmd_ready;
        w_rx_pend_next   = 1'b0;
        w_rx_valid_next  = r_rx_pend;
        w_rx_data_next   = r_rx_pend ? r_rxsh : r_rx_data;

        unique case (r_state)
            S_IDLE: begin
                w_cmd_ready_next = 1'b1;
                if (cmd_valid && r_cmd_ready) begin
                    w_state_next     = S_SETUP;
                    w_cmd_ready_next = 1'b0;
                    w_len_next       = w_len;
                    w_rw_next        = cmd_rw;
                    w_sh_next        = w_header;
                    w_sdi_next       = w_header[7];
                    w_cs_next        = 1'b0;
                    w_div_next       = 8'd0;
                    w_bit_next       = 3'd0;
                    w_byte_next      = '0;
                end
            end
            S_SETUP: begin
                if (w_div_end) begin
                    w_state_next = S_SHIFT;
                    w_spc_next   = 1'b0;
                    w_div_next   = 8'd0;
                end else begin
                    w_div_next = r_div + 8'd1;
                end
            end
            S_SHIFT: begin
                if (!w_div_end) begin
                    w_div_next = r_div + 8'd1;
                end else begin
                    w_div_next = 8'd0;
                    if (!r_spc) begin
                        // Rising edge: sample sdo; only data-phase bytes of a read are delivered.
                        w_spc_next  = 1'b1;
                        w_rxsh_next = {r_rxsh[6:0], sdo};
                        w_rx_pend_next = w_last_bit && (r_byte != '0) && r_rw;
                    end else if (w_last_bit && w_last_byte) begin
                        w_state_next = S_HOLD;
                    end else begin
                        w_spc_next = 1'b0;
                        if (w_last_bit) begin
                            w_bit_next  = 3'd0;
                            w_byte_next = r_byte + ONE_LEN;
                            w_sh_next   = w_new_byte;
                            w_sdi_next  = w_new_byte[7];
                        end else begin
                            w_bit_next = r_bit + 3'd1;
                            w_sh_next  = {r_sh[6:0], 1'b0};
                            w_sdi_next = r_sh[6];
                        end
                    end
                end
            end
            S_HOLD: begin
                if (w_div_end) begin
                    w_state_next = S_GAP;
                    w_cs_next    = 1'b1;
                    w_sdi_next   = 1'b0;
                    w_div_next   = 8'd0;
                    w_gap_next   = 8'd0;
                end else begin
                    w_div_next = r_div + 8'd1;
                end
            end
            S_GAP: begin
                if (r_gap == GAP_LAST) begin
                    w_state_next     = S_IDLE;
                    w_cmd_ready_next = 1'b1;
                end else begin
                    w_gap_next = r_gap + 8'd1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_div       <= 8'd0;
            r_gap       <= 8'd0;
            r_bit       <= 3'd0;
            r_byte      <= '0;
            r_len       <= '0;
            r_rw        <= 1'b0;
            r_sh        <= 8'h00;
            r_rxsh      <= 8'h00;
            r_rx_pend   <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_rx_data   <= 8'h00;
            r_cs        <= 1'b1;
            r_spc       <= 1'b1;
            r_sdi       <= 1'b0;
            r_cmd_ready <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_div       <= w_div_next;
            r_gap       <= w_gap_next;
            r_bit       <= w_bit_next;
            r_byte      <= w_byte_next;
            r_len       <= w_len_next;
            r_rw        <= w_rw_next;
            r_sh        <= w_sh_next;
            r_rxsh      <= w_rxsh_next;
            r_rx_pend   <= w_rx_pend_next;
            r_rx_valid  <= w_rx_valid_next;
            r_rx_data   <= w_rx_data_next;
            r_cs        <= w_cs_next;
            r_spc       <= w_spc_next;
            r_sdi       <= w_sdi_next;
            r_cmd_ready <= w_cmd_ready_next;
        end
    end

endmodule

// File: tb/tb_spi_burst_master.sv
// Directed bench for spi_burst_master (CLK_DIV=1, MAX_BYTES=6, CS_GAP=2) with an inline SPI slave model.
module tb_spi_burst_master;

    localparam int CLK_DIV   = 1;
    localparam int MAX_BYTES = 6;
    localparam int CS_GAP    = 2;
    localparam int LW        = $clog2(MAX_BYTES + 1);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_rw = 1'b0;
    logic [5:0]    cmd_addr = 6'd0;
    logic [LW-1:0] cmd_len = '0;
    logic [7:0]    tx_data = 8'h00;
    logic          sdo = 1'b1;
    logic          cmd_ready, tx_ready, rx_valid, busy, done, cs, spc, sdi;
    logic [7:0]    rx_data;

    spi_burst_master #(.CLK_DIV(CLK_DIV), .MAX_BYTES(MAX_BYTES), .CS_GAP(CS_GAP)) dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .tx_data(tx_data),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
        .done(done), .sdo(sdo), .cs(cs), .spc(spc), .sdi(sdi)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    int obs_fall, obs_tx, obs_rx, obs_done, obs_acc, obs_cs_low, obs_busy_err;
    int first_done_cyc, second_acc_cyc, min_gap;
    logic       timed_out;
    logic [7:0] mosi   [0:7];
    logic [7:0] rx_log [0:7];
    logic [7:0] tx_q   [0:7];
    logic [7:0] miso_q [0:7];

    // Issues one command (or, with hold set, keeps cmd_valid high for n_txn commands) and
    // plays the slave: sdo shifts on spc falls (all ones during the header), sdi is captured on rises.
    task automatic run_txn(input logic rw, input logic [5:0] addr, input logic [LW-1:0] len,
                           input int n_txn, input logic hold);
        int   cyc, fidx, ridx, cs_high_run;
        logic prev_spc, prev_cs;
        obs_fall = 0; obs_tx = 0; obs_rx = 0; obs_done = 0; obs_acc = 0;
        obs_cs_low = 0; obs_busy_err = 0;
        first_done_cyc = -1; second_acc_cyc = -1; min_gap = 1000;
        for (int i = 0; i < 8; i++) begin
            mosi[i] = 8'h00;
            rx_log[i] = 8'h00;
        end
        cyc = 0; fidx = 0; ridx = 0; cs_high_run = 0; prev_spc = 1'b1; prev_cs = 1'b1;
        @(negedge clk);
        cmd_rw = rw; cmd_addr = addr; cmd_len = len; cmd_valid = 1'b1;
        while (obs_done < n_txn && cyc < 2000) begin
            cyc++;
            if (cmd_valid && cmd_ready) begin
                obs_acc++;
                if (obs_acc == 2) second_acc_cyc = cyc;
            end else if (obs_acc >= (hold ? n_txn : 1) && !cmd_ready) begin
                cmd_valid = 1'b0;
            end
            if (!cs) begin
                obs_cs_low++;
                if (!busy) obs_busy_err++;
            end
            if (done) begin
                obs_done++;
                if (obs_done == 1) first_done_cyc = cyc;
            end
            if (tx_ready) begin
                tx_data = tx_q[3'(obs_tx)];
                obs_tx++;
            end
            if (rx_valid) begin
                rx_log[3'(obs_rx)] = rx_data;
                obs_rx++;
            end
            if (!cs && prev_spc && !spc) begin
                sdo = (fidx < 8) ? 1'b1 : miso_q[3'(fidx / 8 - 1)][3'(7 - fidx % 8)];
                fidx++;
                obs_fall++;
            end
            if (!cs && !prev_spc && spc) begin
                mosi[3'(ridx / 8)][3'(7 - ridx % 8)] = sdi;
                ridx++;
            end
            if (cs) begin
                cs_high_run++;
                fidx = 0;
                ridx = 0;
            end else begin
                if (prev_cs && obs_done > 0 && cs_high_run < min_gap) min_gap = cs_high_run;
                cs_high_run = 0;
            end
            prev_spc = spc;
            prev_cs  = cs;
            if (obs_done < n_txn) @(negedge clk);
        end
        cmd_valid = 1'b0;
        timed_out = (obs_done < n_txn);
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if (cs !== 1'b1)        begin n_bad++; $display("FAIL reset_cs: got %b want 1", cs); end
        n_cmp++; if (spc !== 1'b1)       begin n_bad++; $display("FAIL reset_spc: got %b want 1", spc); end
        n_cmp++; if (sdi !== 1'b0)       begin n_bad++; $display("FAIL reset_sdi: got %b want 0", sdi); end
        n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready); end
        n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0)      begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (tx_ready !== 1'b0)  begin n_bad++; $display("FAIL reset_tx_ready: got %b want 0", tx_ready); end
        n_cmp++; if (rx_valid !== 1'b0)  begin n_bad++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        n_cmp++; if (rx_data !== 8'h00)  begin n_bad++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_release_ready: got %b want 1", cmd_ready); end
    endtask

    task automatic test_write();
        tx_q[0] = 8'h97;
        run_txn(1'b0, 6'h20, 3'd1, 1, 1'b0);
        n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL write_timeout: got %b want 0", timed_out); end
        n_cmp++; if (mosi[0] !== 8'h20)  begin n_bad++; $display("FAIL write_header: got %h want 20", mosi[0]); end
        n_cmp++; if (mosi[1] !== 8'h97)  begin n_bad++; $display("FAIL write_data: got %h want 97", mosi[1]); end
        n_cmp++; if (obs_fall !== 16)    begin n_bad++; $display("FAIL write_spc_falls: got %0d want 16", obs_fall); end
        n_cmp++; if (obs_tx !== 1)       begin n_bad++; $display("FAIL write_tx_ready: got %0d want 1", obs_tx); end
        n_cmp++; if (obs_done !== 1)     begin n_bad++; $display("FAIL write_done: got %0d want 1", obs_done); end
        n_cmp++; if (obs_cs_low !== 34)  begin n_bad++; $display("FAIL write_cs_low: got %0d want 34", obs_cs_low); end
        n_cmp++; if (obs_rx !== 0)       begin n_bad++; $display("FAIL write_rx_valid: got %0d want 0", obs_rx); end
        n_cmp++; if (obs_busy_err !== 0) begin n_bad++; $display("FAIL write_busy: got %0d idle cycles with cs low, want 0", obs_busy_err); end
    endtask

    task automatic test_burst_read();
        for (int i = 0; i < 8; i++) miso_q[i] = 8'hA0 + 8'(i);
        run_txn(1'b1, 6'h28, 3'd6, 1, 1'b0);
        n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL read_timeout: got %b want 0", timed_out); end
        n_cmp++; if (mosi[0] !== 8'hE8)  begin n_bad++; $display("FAIL read_header: got %h want e8", mosi[0]); end
        n_cmp++; if (mosi[1] !== 8'h00)  begin n_bad++; $display("FAIL read_sdi_data_phase: got %h want 00", mosi[1]); end
        n_cmp++; if (obs_fall !== 56)    begin n_bad++; $display("FAIL read_spc_falls: got %0d want 56", obs_fall); end
        n_cmp++; if (obs_rx !== 6)       begin n_bad++; $display("FAIL read_rx_count: got %0d want 6", obs_rx); end
        n_cmp++; if (obs_tx !== 0)       begin n_bad++; $display("FAIL read_tx_ready: got %0d want 0", obs_tx); end
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (rx_log[i] !== 8'hA0 + 8'(i)) begin
                n_bad++; $display("FAIL read_rx_data[%0d]: got %h want %h", i, rx_log[i], 8'hA0 + 8'(i));
            end
        end
    endtask

    task automatic test_clamp();
        for (int i = 0; i < 8; i++) tx_q[i] = 8'h11 + 8'(i);
        run_txn(1'b0, 6'h05, 3'd7, 1, 1'b0);
        n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL clamp_timeout: got %b want 0", timed_out); end
        n_cmp++; if (mosi[0] !== 8'h45)  begin n_bad++; $display("FAIL clamp_header: got %h want 45", mosi[0]); end
        n_cmp++; if (obs_fall !== 56)    begin n_bad++; $display("FAIL clamp_spc_falls: got %0d want 56", obs_fall); end
        n_cmp++; if (obs_tx !== 6)       begin n_bad++; $display("FAIL clamp_tx_count: got %0d want 6", obs_tx); end
        for (int i = 1; i <= 6; i++) begin
            n_cmp++;
            if (mosi[i] !== 8'h10 + 8'(i)) begin
                n_bad++; $display("FAIL clamp_data[%0d]: got %h want %h", i, mosi[i], 8'h10 + 8'(i));
            end
        end
    endtask

    task automatic test_header_only();
        run_txn(1'b1, 6'h0F, 3'd0, 1, 1'b0);
        n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL hdr_timeout: got %b want 0", timed_out); end
        n_cmp++; if (mosi[0] !== 8'h8F)  begin n_bad++; $display("FAIL hdr_header: got %h want 8f", mosi[0]); end
        n_cmp++; if (obs_fall !== 8)     begin n_bad++; $display("FAIL hdr_spc_falls: got %0d want 8", obs_fall); end
        n_cmp++; if (obs_rx !== 0)       begin n_bad++; $display("FAIL hdr_rx_valid: got %0d want 0", obs_rx); end
        n_cmp++; if (obs_done !== 1)     begin n_bad++; $display("FAIL hdr_done: got %0d want 1", obs_done); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) miso_q[i] = 8'h5A;
        run_txn(1'b1, 6'h11, 3'd1, 2, 1'b1);
        n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL b2b_timeout: got %b want 0", timed_out); end
        n_cmp++; if (obs_acc !== 2)      begin n_bad++; $display("FAIL b2b_accepts: got %0d want 2", obs_acc); end
        n_cmp++;
        if (second_acc_cyc !== first_done_cyc + 1) begin
            n_bad++; $display("FAIL b2b_accept_cycle: got %0d want %0d", second_acc_cyc, first_done_cyc + 1);
        end
        n_cmp++; if (min_gap < CS_GAP)   begin n_bad++; $display("FAIL b2b_cs_gap: got %0d want >= %0d", min_gap, CS_GAP); end
        n_cmp++; if (obs_rx !== 2)       begin n_bad++; $display("FAIL b2b_rx_count: got %0d want 2", obs_rx); end
    endtask

    task automatic test_reset_mid_op();
        int   falls, cyc, done_seen;
        logic prev_spc, acc;
        falls = 0; cyc = 0; done_seen = 0; prev_spc = 1'b1; acc = 1'b0;
        @(negedge clk);
        cmd_rw = 1'b0; cmd_addr = 6'h01; cmd_len = 3'd2; cmd_valid = 1'b1;
        // Byte 1 bit 3 is driven on the 13th spc fall (8 header falls, then bits 7..3).
        while (falls < 13 && cyc < 500) begin
            if (cmd_valid && cmd_ready) acc = 1'b1;
            else if (acc && !cmd_ready) cmd_valid = 1'b0;
            if (tx_ready) tx_data = 8'h3C;
            if (!cs && prev_spc && !spc) falls++;
            prev_spc = spc;
            cyc++;
            if (falls < 13) @(negedge clk);
        end
        cmd_valid = 1'b0;
        n_cmp++; if (cs !== 1'b0) begin n_bad++; $display("FAIL rst_mid_active: got cs %b want 0", cs); end
        reset_n = 1'b0;
        #1;
        n_cmp++; if (cs !== 1'b1)   begin n_bad++; $display("FAIL rst_mid_cs: got %b want 1", cs); end
        n_cmp++; if (spc !== 1'b1)  begin n_bad++; $display("FAIL rst_mid_spc: got %b want 1", spc); end
        n_cmp++; if (sdi !== 1'b0)  begin n_bad++; $display("FAIL rst_mid_sdi: got %b want 0", sdi); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        reset_n = 1'b1;
        @(negedge clk);
        if (done) done_seen++;
        n_cmp++; if (done_seen !== 0)    begin n_bad++; $display("FAIL rst_mid_done: got %0d pulses want 0", done_seen); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_mid_ready: got %b want 1", cmd_ready); end
        tx_q[0] = 8'hC3;
        run_txn(1'b0, 6'h2A, 3'd1, 1, 1'b0);
        n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL rst_after_timeout: got %b want 0", timed_out); end
        n_cmp++; if (mosi[0] !== 8'h2A)  begin n_bad++; $display("FAIL rst_after_header: got %h want 2a", mosi[0]); end
        n_cmp++; if (mosi[1] !== 8'hC3)  begin n_bad++; $display("FAIL rst_after_data: got %h want c3", mosi[1]); end
        n_cmp++; if (obs_fall !== 16)    begin n_bad++; $display("FAIL rst_after_falls: got %0d want 16", obs_fall); end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            tx_q[i] = 8'h00;
            miso_q[i] = 8'h00;
        end
        test_reset();
        test_write();
        test_burst_read();
        test_clamp();
        test_header_only();
        test_back_to_back();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
